// File: rtl/run_pattern_tx.sv
// run_pattern_tx: turns queued {bit, length} run commands into a gapless serial
// w stream for the run-of-four detector, and produces exp_z, a registered model
// of that detector's z output.
module run_pattern_tx #(
    parameter int LEN_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int RUN_THRESH = 4
) (
    input  logic                          Clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    input  logic                          cmd_bit,
    input  logic [LEN_W-1:0]              cmd_len,
    output logic                          cmd_ready,
    output logic                          w_out,
    output logic                          w_valid,
    output logic                          exp_z,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(RUN_THRESH + 1);

    typedef enum logic {IDLE, EMIT} state_t;

    typedef struct packed {
        logic             val;
        logic [LEN_W-1:0] len;
    } cmd_t;

    state_t                state_q, state_d;
    cmd_t                  mem_q [FIFO_DEPTH];
    cmd_t                  mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  val_q, val_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  w_out_q, w_out_d;
    logic                  w_valid_q, w_valid_d;
    logic                  busy_q, busy_d;
    logic [RUN_THRESH-1:0] hist_q, hist_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  exp_z_q, exp_z_d;

    cmd_t                  head;
    logic                  have_head;
    logic                  push;
    logic                  pop;

    // Next-state: FIFO bookkeeping, run sequencing, registered outputs and the z model.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        val_d     = val_q;
        rem_d     = rem_q;
        hist_d    = hist_q;
        cnt_d     = cnt_q;
        pop       = 1'b0;
        head      = mem_q[rd_ptr_q];
        have_head = (level_q != '0);
        push      = cmd_valid && cmd_ready_q;

        case (state_q)
            IDLE: begin
                if (have_head) begin
                    // A zero-length head is popped and dropped, costing one idle cycle.
                    pop = 1'b1;
                    if (head.len != '0) begin
                        state_d = EMIT;
                        val_d   = head.val;
                        rem_d   = head.len;
                    end
                end
            end
            EMIT: begin
                rem_d = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    // Chain straight into the next non-empty run to keep the stream gapless.
                    if (have_head && head.len != '0) begin
                        pop   = 1'b1;
                        val_d = head.val;
                        rem_d = head.len;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = '{val: cmd_bit, len: cmd_len};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
        cmd_ready_d = (level_d < LVL_W'(FIFO_DEPTH));

        w_valid_d = (state_d == EMIT);
        w_out_d   = w_valid_d && val_d;
        busy_d    = w_valid_d || (level_d != '0);

        // The detector model only advances on cycles that carried an emitted bit.
        if (w_valid_q) begin
            hist_d = {hist_q[RUN_THRESH-2:0], w_out_q};
            if (cnt_q != CNT_W'(RUN_THRESH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        exp_z_d = (cnt_d == CNT_W'(RUN_THRESH)) && ((hist_d == '0) || (hist_d == '1));
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            val_q       <= 1'b0;
            rem_q       <= '0;
            cmd_ready_q <= 1'b1;
            w_out_q     <= 1'b0;
            w_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            hist_q      <= '0;
            cnt_q       <= '0;
            exp_z_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            val_q       <= val_d;
            rem_q       <= rem_d;
            cmd_ready_q <= cmd_ready_d;
            w_out_q     <= w_out_d;
            w_valid_q   <= w_valid_d;
            busy_q      <= busy_d;
            hist_q      <= hist_d;
            cnt_q       <= cnt_d;
            exp_z_q     <= exp_z_d;
        end
    end

    // Command storage.
    always_ff @(posedge Clk) begin
        // NOTE: storage is not reset; the pointers and level decide which entries are live.
        mem_q <= mem_d;
    end

    assign cmd_ready  = cmd_ready_q;
    assign w_out      = w_out_q;
    assign w_valid    = w_valid_q;
    assign exp_z      = exp_z_q;
    assign fifo_level = level_q;
    assign busy       = busy_q;

endmodule
